// File: rtl/rotation_parser_if.sv
// Byte-stream in / rotation-record out handshake bundle for rotation_parser.
// The parser side uses the slave modport; the source/sink environment uses master.
interface rotation_parser_if;
    // Input byte stream
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;

    // Output rotation records
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );
endinterface

// File: rtl/rotation_parser.sv
// Parses ASCII rotation records ("L68", "R48", ...) from a byte stream into
// signed 32-bit rotations. Malformed records are discarded and counted; a
// one-entry output register decouples the parser from the downstream stage.
module rotation_parser #(
    parameter int MAX_DIGITS = 9
) (
    input  logic               clk,
    input  logic               rst,
    rotation_parser_if.slave   bus,
    output logic [15:0]        rec_count,
    output logic [7:0]         err_count,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIGITS = 2'd1,
        ERR    = 2'd2
    } state_t;

    // Parser state
    state_t      state_reg, state_next;
    logic        sign_reg, sign_next;
    logic [29:0] mag_reg, mag_next;
    logic [3:0]  cnt_reg, cnt_next;

    // Output holding register and status
    logic        out_valid_reg;
    logic [31:0] out_data_reg;
    logic [15:0] rec_count_reg;
    logic [7:0]  err_count_reg;
    logic        done_reg;
    logic        last_pending_reg;   // in_last consumed, its record not yet handed off

    // Per-cycle decisions
    logic        fire;
    logic        load;
    logic        err_inc;
    logic [31:0] load_value;
    logic        out_hs;

    // Byte classes
    logic        is_dir;
    logic        is_digit;
    logic        is_term;
    logic        is_space;

    // Classify the offered byte
    always_comb begin
        is_dir   = (bus.in_data == 8'h4C) || (bus.in_data == 8'h52);
        is_digit = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
        is_term  = (bus.in_data == 8'h0A) || (bus.in_data == 8'h0D) ||
                   (bus.in_data == 8'h2C);
        is_space = (bus.in_data == 8'h20);
    end

    // Accept a byte whenever the holding register can take a result this cycle
    assign bus.in_ready = !done_reg && (!out_valid_reg || bus.out_ready);
    assign fire         = bus.in_valid && bus.in_ready;
    assign out_hs       = out_valid_reg && bus.out_ready;

    // Next-state / datapath decode for the consumed byte, then the implicit
    // terminator that in_last adds after the byte has been processed
    always_comb begin
        state_next = state_reg;
        sign_next  = sign_reg;
        mag_next   = mag_reg;
        cnt_next   = cnt_reg;
        load       = 1'b0;
        err_inc    = 1'b0;

        if (fire) begin
            case (state_reg)
                IDLE: begin
                    if (is_dir) begin
                        sign_next  = (bus.in_data == 8'h4C);
                        mag_next   = 30'd0;
                        cnt_next   = 4'd0;
                        state_next = DIGITS;
                    end else if (is_term || is_space) begin
                        // empty lines and leading spaces are skipped
                        state_next = IDLE;
                    end else begin
                        state_next = ERR;
                        err_inc    = 1'b1;
                    end
                end
                DIGITS: begin
                    if (is_digit && (cnt_reg < 4'(MAX_DIGITS))) begin
                        mag_next = 30'(mag_reg * 30'd10) + {26'd0, bus.in_data[3:0]};
                        cnt_next = cnt_reg + 4'd1;
                    end else if (is_term) begin
                        // a bare direction letter is a malformed record
                        if (cnt_reg != 4'd0) begin
                            load = 1'b1;
                        end else begin
                            err_inc = 1'b1;
                        end
                        state_next = IDLE;
                    end else begin
                        // too many digits, stray direction, space or illegal byte
                        state_next = ERR;
                        err_inc    = 1'b1;
                    end
                end
                ERR: begin
                    if (is_term) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase

            // An explicit terminator already left us in IDLE, so this only
            // acts when the final byte did not close the record itself.
            if (bus.in_last) begin
                case (state_next)
                    DIGITS: begin
                        if (cnt_next != 4'd0) begin
                            load = 1'b1;
                        end else begin
                            err_inc = 1'b1;
                        end
                        state_next = IDLE;
                    end
                    ERR: begin
                        state_next = IDLE;
                    end
                    default: begin
                        state_next = state_next;
                    end
                endcase
            end
        end
    end

    // Sign-apply the accumulated magnitude for the output register
    always_comb begin
        load_value = {2'b00, mag_next};
        if (sign_next) begin
            load_value = -{2'b00, mag_next};
        end
    end

    // FSM and accumulator registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sign_reg  <= 1'b0;
            mag_reg   <= 30'd0;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            sign_reg  <= sign_next;
            mag_reg   <= mag_next;
            cnt_reg   <= cnt_next;
        end
    end

    // One-entry output holding register; a load can coincide with the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= 32'd0;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= load_value;
        end else if (out_hs) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Record counter wraps, error counter saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            rec_count_reg <= 16'd0;
            err_count_reg <= 8'd0;
        end else begin
            if (out_hs) begin
                rec_count_reg <= rec_count_reg + 16'd1;
            end
            if (err_inc && (err_count_reg != 8'hFF)) begin
                err_count_reg <= err_count_reg + 8'd1;
            end
        end
    end

    // End-of-input tracking: done follows the last byte, or the handoff of
    // the record that the last byte completed
    always_ff @(posedge clk) begin
        if (rst) begin
            done_reg         <= 1'b0;
            last_pending_reg <= 1'b0;
        end else begin
            if (fire && bus.in_last) begin
                if (load) begin
                    last_pending_reg <= 1'b1;
                end else begin
                    done_reg <= 1'b1;
                end
            end
            if (last_pending_reg && out_hs) begin
                done_reg         <= 1'b1;
                last_pending_reg <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign rec_count     = rec_count_reg;
    assign err_count     = err_count_reg;
    assign done          = done_reg;

endmodule

// File: tb/tb_rotation_parser.sv
// Directed bench for rotation_parser: each task drives one scenario and checks
// its hand-computed results inline.
module tb_rotation_parser;

    logic        clk;
    logic        rst;
    logic [15:0] rec_count;
    logic [7:0]  err_count;
    logic        done;

    int vectors;
    int miscompares;
    int got_q[$];

    rotation_parser_if bus ();

    rotation_parser #(.MAX_DIGITS(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .rec_count (rec_count),
        .err_count (err_count),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture each accepted record (handshake happens at the next rising edge)
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            got_q.push_back($signed(bus.out_data));
            $display("record out: %0d", $signed(bus.out_data));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 2ms", $time);
        $fatal(1);
    end

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'h00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_last  = last;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            miscompares++;
            $display("FAIL send_timeout: in_ready got 0 required 1 for byte %02h", b);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_string(input string s, input bit last_on_end);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], last_on_end && (i == s.len() - 1));
        end
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
        vectors++;
        if (bus.out_data !== 32'd0) begin miscompares++; $display("FAIL reset_out_data: got %h required 0", bus.out_data); end
        vectors++;
        if (rec_count !== 16'd0 || err_count !== 8'd0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: got rec %0d err %0d done %b required 0 0 0", rec_count, err_count, done);
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        do_reset();
        bus.out_ready = 1'b1;
        send_string("L68\n", 1'b0);
        vectors++;
        if (bus.out_valid !== 1'b1 || $signed(bus.out_data) !== -68) begin
            miscompares++;
            $display("FAIL basic_first: got valid %b data %0d required 1 -68", bus.out_valid, $signed(bus.out_data));
        end
        send_string("R48\n", 1'b0);
        vectors++;
        if (bus.out_valid !== 1'b1 || $signed(bus.out_data) !== 48) begin
            miscompares++;
            $display("FAIL basic_second: got valid %b data %0d required 1 48", bus.out_valid, $signed(bus.out_data));
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drop: out_valid got %b required 0", bus.out_valid); end
        vectors++;
        if (rec_count !== 16'd2) begin miscompares++; $display("FAIL basic_rec_count: got %0d required 2", rec_count); end
        vectors++;
        if (got_q.size() != 2) begin
            miscompares++;
            $display("FAIL basic_records: got %0d records required 2", got_q.size());
        end else if (got_q[0] != -68 || got_q[1] != 48) begin
            miscompares++;
            $display("FAIL basic_records: got %0d,%0d required -68,48", got_q[0], got_q[1]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.out_ready = 1'b0;
        send_string("R5\n", 1'b0);
        vectors++;
        if (bus.out_valid !== 1'b1 || $signed(bus.out_data) !== 5) begin
            miscompares++;
            $display("FAIL stall_load: got valid %b data %0d required 1 5", bus.out_valid, $signed(bus.out_data));
        end
        fork
            send_string("L3\n", 1'b0);
            begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    vectors++;
                    if (bus.in_ready !== 1'b0 || $signed(bus.out_data) !== 5 || bus.out_valid !== 1'b1) begin
                        miscompares++;
                        $display("FAIL stall_hold: got ready %b valid %b data %0d required 0 1 5",
                                 bus.in_ready, bus.out_valid, $signed(bus.out_data));
                    end
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        vectors++;
        if (bus.out_valid !== 1'b1 || $signed(bus.out_data) !== -3) begin
            miscompares++;
            $display("FAIL stall_next: got valid %b data %0d required 1 -3", bus.out_valid, $signed(bus.out_data));
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (got_q.size() != 2) begin
            miscompares++;
            $display("FAIL stall_records: got %0d records required 2", got_q.size());
        end else if (got_q[0] != 5 || got_q[1] != -3) begin
            miscompares++;
            $display("FAIL stall_records: got %0d,%0d required 5,-3", got_q[0], got_q[1]);
        end
        vectors++;
        if (rec_count !== 16'd2) begin miscompares++; $display("FAIL stall_rec_count: got %0d required 2", rec_count); end
    endtask

    task automatic test_errors();
        do_reset();
        bus.out_ready = 1'b1;
        send_string("X12\nL\nR1234567890\nR7\n", 1'b0);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (err_count !== 8'd3) begin miscompares++; $display("FAIL err_count: got %0d required 3", err_count); end
        vectors++;
        if (rec_count !== 16'd1) begin miscompares++; $display("FAIL err_rec_count: got %0d required 1", rec_count); end
        vectors++;
        if (got_q.size() != 1) begin
            miscompares++;
            $display("FAIL err_records: got %0d records required 1", got_q.size());
        end else if (got_q[0] != 7) begin
            miscompares++;
            $display("FAIL err_records: got %0d required 7", got_q[0]);
        end
    endtask

    task automatic test_last();
        do_reset();
        bus.out_ready = 1'b1;
        send_string("\r\n\n L999999999", 1'b1);
        vectors++;
        if (bus.out_valid !== 1'b1 || $signed(bus.out_data) !== -999999999 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL last_record: got valid %b data %0d done %b required 1 -999999999 0",
                     bus.out_valid, $signed(bus.out_data), done);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b1 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL last_done: got done %b in_ready %b required 1 0", done, bus.in_ready);
        end
        vectors++;
        if (got_q.size() != 1 || rec_count !== 16'd1 || err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL last_counts: got records %0d rec %0d err %0d required 1 1 0", got_q.size(), rec_count, err_count);
        end

        // explicit terminator carrying in_last counts as a single terminator
        do_reset();
        send_string("R2\n", 1'b1);
        vectors++;
        if (bus.out_valid !== 1'b1 || $signed(bus.out_data) !== 2) begin
            miscompares++;
            $display("FAIL last_term: got valid %b data %0d required 1 2", bus.out_valid, $signed(bus.out_data));
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b1 || rec_count !== 16'd1 || err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL last_term_counts: got done %b rec %0d err %0d required 1 1 0", done, rec_count, err_count);
        end

        // final byte yields no record: done the cycle after that byte
        do_reset();
        send_string("L5,X", 1'b1);
        vectors++;
        if (done !== 1'b1 || err_count !== 8'd1 || rec_count !== 16'd1) begin
            miscompares++;
            $display("FAIL last_noreq: got done %b err %0d rec %0d required 1 1 1", done, err_count, rec_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready = 1'b1;
        send_string("R4", 1'b0);
        do_reset();
        send_string("L1\n", 1'b0);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (got_q.size() != 1 || rec_count !== 16'd1 || err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL midrst_counts: got records %0d rec %0d err %0d required 1 1 0", got_q.size(), rec_count, err_count);
        end else if (got_q[0] != -1) begin
            miscompares++;
            $display("FAIL midrst_value: got %0d required -1", got_q[0]);
        end

        // pending output dropped by reset
        do_reset();
        bus.out_ready = 1'b0;
        send_string("R9\n", 1'b0);
        do_reset();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || rec_count !== 16'd0 || got_q.size() != 0) begin
            miscompares++;
            $display("FAIL pendrst: got valid %b rec %0d records %0d required 0 0 0", bus.out_valid, rec_count, got_q.size());
        end
    endtask

    task automatic test_saturate();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_string("?\n", 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (err_count !== 8'd255) begin miscompares++; $display("FAIL sat_err_count: got %0d required 255", err_count); end
        vectors++;
        if (got_q.size() != 0 || rec_count !== 16'd0) begin
            miscompares++;
            $display("FAIL sat_records: got records %0d rec %0d required 0 0", got_q.size(), rec_count);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        bus.out_ready = 1'b1;

        test_reset();
        test_basic();
        test_back_to_back();
        test_errors();
        test_last();
        test_reset_mid();
        test_saturate();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
